// File: rtl/ball_motion_ctrl_if.sv
// rtl/ball_motion_ctrl_if.sv - scan, paddle and ball signal bundle for ball_motion_ctrl
// Purpose: groups the pixel-scan inputs, paddle/serve controls and ball outputs
//          of the breakout ball controller into one bundle.
// Signals:
//   pTick      1   pixel enable from the sync generator
//   pixelX     10  current scan column
//   pixelY     10  current scan line
//   paddleX    10  paddle left edge
//   start      1   serve request (level)
//   ballX      10  ball left edge
//   ballY      10  ball top edge
//   squareBall 1   current pixel lies inside the ball
//   miss       1   one-clock pulse on ball loss
//   lives      2   remaining lives
//   state      2   SERVE=0, MOVE=1, MISS=2, OVER=3
// Modports: master drives scan/paddle/start, slave (the controller) drives ball outputs.
interface ball_motion_ctrl_if;
  logic       pTick;
  logic [9:0] pixelX;
  logic [9:0] pixelY;
  logic [9:0] paddleX;
  logic       start;
  logic [9:0] ballX;
  logic [9:0] ballY;
  logic       squareBall;
  logic       miss;
  logic [1:0] lives;
  logic [1:0] state;

  modport master (
    output pTick, pixelX, pixelY, paddleX, start,
    input  ballX, ballY, squareBall, miss, lives, state
  );

  modport slave (
    input  pTick, pixelX, pixelY, paddleX, start,
    output ballX, ballY, squareBall, miss, lives, state
  );
endinterface

// File: rtl/ball_motion_ctrl.sv
// rtl/ball_motion_ctrl.sv - breakout ball serve/move/miss sequencer, one update per frame
// Purpose: moves and bounces the ball once per frame during vertical blank and
//          flags the pixels covered by the ball for the colour mux.
// Ports:
//   clock  system clock
//   reset  asynchronous active-low reset
//   bus    ball_motion_ctrl_if.slave (scan/paddle/start in, ball/miss/lives/state out)
// Option: BALL_LIVES_EN enables lives counting and the OVER state; without it
//         lives stays 3 and every miss returns to SERVE through MISS.
module ball_motion_ctrl #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL_SIZE   = 8,
  parameter int SPEED       = 2,
  parameter int SERVE_X     = 316,
  parameter int SERVE_Y     = 240,
  parameter int PADDLE_Y    = 460,
  parameter int PADDLE_W    = 64,
  parameter int MISS_FRAMES = 60
) (
  input logic               clock,
  input logic               reset,
  ball_motion_ctrl_if.slave bus
);

  localparam logic [1:0] ST_SERVE = 2'd0;
  localparam logic [1:0] ST_MOVE  = 2'd1;
  localparam logic [1:0] ST_MISS  = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  // 11-bit constants so every sum and compare below is free of wrap.
  localparam logic [10:0] H_W  = 11'(H_RES);
  localparam logic [10:0] V_W  = 11'(V_RES);
  localparam logic [10:0] BS_W = 11'(BALL_SIZE);
  localparam logic [10:0] SP_W = 11'(SPEED);
  localparam logic [10:0] PY_W = 11'(PADDLE_Y);
  localparam logic [10:0] PW_W = 11'(PADDLE_W);
  localparam logic [9:0]  SERVE_X_W = 10'(SERVE_X);
  localparam logic [9:0]  SERVE_Y_W = 10'(SERVE_Y);
  localparam logic [9:0]  V_RES_W   = 10'(V_RES);
  localparam logic [7:0]  MISS_W    = 8'(MISS_FRAMES);

  logic [9:0] ball_x_q, ball_x_d;
  logic [9:0] ball_y_q, ball_y_d;
  logic       dir_x_q, dir_x_d;   // 1 = moving right
  logic       dir_y_q, dir_y_d;   // 1 = moving down
  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] lives_q, lives_d;
  logic       miss_q, miss_d;

  logic        frame_tick;
  logic [10:0] x_ext, y_ext, px_ext, bot_ext;
  logic        paddle_hit, bottom_hit;
  logic [9:0]  x_mv, y_mv;
  logic        dir_x_mv, dir_y_mv;

  // First blanking line, first column: once per frame, always inside vertical blank.
  assign frame_tick = bus.pTick && (bus.pixelX == 10'd0) && (bus.pixelY == V_RES_W);

  // Candidate position for one MOVE frame; X and Y resolve independently so a
  // corner reflects both axes at once.
  always_comb begin
    x_ext    = {1'b0, ball_x_q};
    y_ext    = {1'b0, ball_y_q};
    px_ext   = {1'b0, bus.paddleX};
    bot_ext  = y_ext + BS_W;
    paddle_hit = (bot_ext <= PY_W) && (bot_ext + SP_W >= PY_W) &&
                 (x_ext + BS_W > px_ext) && (x_ext < px_ext + PW_W);
    bottom_hit = (bot_ext + SP_W >= V_W);
    x_mv     = ball_x_q;
    y_mv     = ball_y_q;
    dir_x_mv = dir_x_q;
    dir_y_mv = dir_y_q;

    if (dir_x_q) begin
      if (x_ext + BS_W + SP_W >= H_W) begin
        x_mv     = 10'(H_W - BS_W);
        dir_x_mv = 1'b0;
      end else begin
        x_mv = 10'(x_ext + SP_W);
      end
    end else if (x_ext <= SP_W) begin
      x_mv     = 10'd0;
      dir_x_mv = 1'b1;
    end else begin
      x_mv = 10'(x_ext - SP_W);
    end

    if (!dir_y_q) begin
      if (y_ext <= SP_W) begin
        y_mv     = 10'd0;
        dir_y_mv = 1'b1;
      end else begin
        y_mv = 10'(y_ext - SP_W);
      end
    end else if (paddle_hit) begin
      y_mv     = 10'(PY_W - BS_W);
      dir_y_mv = 1'b0;
    end else begin
      y_mv = 10'(y_ext + SP_W);
    end
  end

  always_comb begin
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    lives_d  = lives_q;
    miss_d   = 1'b0;

    if (frame_tick) begin
      case (state_q)
        ST_SERVE: begin
          if (bus.start) begin
            dir_x_d = 1'b1;
            dir_y_d = 1'b0;
            state_d = ST_MOVE;
          end
        end
        ST_MOVE: begin
          // A miss freezes the ball where it is; paddle_hit already took priority.
          if (dir_y_q && !paddle_hit && bottom_hit) begin
            miss_d = 1'b1;
            cnt_d  = MISS_W;
`ifdef BALL_LIVES_EN
            lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) begin
              state_d  = ST_OVER;
              ball_x_d = SERVE_X_W;
              ball_y_d = SERVE_Y_W;
            end else begin
              state_d = ST_MISS;
            end
`else
            state_d = ST_MISS;
`endif
          end else begin
            ball_x_d = x_mv;
            ball_y_d = y_mv;
            dir_x_d  = dir_x_mv;
            dir_y_d  = dir_y_mv;
          end
        end
        ST_MISS: begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q <= 8'd1) begin
            cnt_d    = 8'd0;
            state_d  = ST_SERVE;
            ball_x_d = SERVE_X_W;
            ball_y_d = SERVE_Y_W;
          end
        end
        ST_OVER: begin
          ball_x_d = SERVE_X_W;
          ball_y_d = SERVE_Y_W;
        end
        default: state_d = ST_SERVE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ball_x_q <= SERVE_X_W;
      ball_y_q <= SERVE_Y_W;
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b0;
      state_q  <= ST_SERVE;
      cnt_q    <= 8'd0;
      lives_q  <= 2'd3;
      miss_q   <= 1'b0;
    end else begin
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lives_q  <= lives_d;
      miss_q   <= miss_d;
    end
  end

  assign bus.ballX = ball_x_q;
  assign bus.ballY = ball_y_q;
  assign bus.state = state_q;
  assign bus.lives = lives_q;
  assign bus.miss  = miss_q;
  assign bus.squareBall = ({1'b0, bus.pixelX} >= x_ext) && ({1'b0, bus.pixelX} < x_ext + BS_W) &&
                          ({1'b0, bus.pixelY} >= y_ext) && ({1'b0, bus.pixelY} < y_ext + BS_W);

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb/tb_ball_motion_ctrl.sv - scoreboard bench for ball_motion_ctrl
module tb_ball_motion_ctrl;
  localparam int H_RES = 640, V_RES = 480, BS = 8, SPEED = 2;
  localparam int SERVE_X = 316, SERVE_Y = 240, PADDLE_Y = 460, PADDLE_W = 64, MISS_FRAMES = 60;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ball_motion_ctrl_if bus();

  ball_motion_ctrl #(
    .H_RES(H_RES), .V_RES(V_RES), .BALL_SIZE(BS), .SPEED(SPEED),
    .SERVE_X(SERVE_X), .SERVE_Y(SERVE_Y), .PADDLE_Y(PADDLE_Y),
    .PADDLE_W(PADDLE_W), .MISS_FRAMES(MISS_FRAMES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int due;
    int x;
    int y;
    int st;
    int lives;
    int miss;
    int sq;
  } exp_t;

  exp_t sbq[$];
  int cyc = 0, checks = 0, errors = 0;
  int m_x, m_y, m_dx, m_dy, m_st, m_cnt, m_lives, m_miss;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int clip(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_x = SERVE_X; m_y = SERVE_Y; m_dx = 1; m_dy = -1;
    m_st = 0; m_cnt = 0; m_lives = 3; m_miss = 0;
  endtask

  function automatic int in_ball(input int px, input int py);
    return (px >= m_x && px < m_x + BS && py >= m_y && py < m_y + BS) ? 1 : 0;
  endfunction

  // One frame of the game rules, in plain integer arithmetic.
  task automatic model_frame(input int padx, input int st);
    int nx, ny, ndx, ndy;
    if (m_st == 0) begin
      if (st != 0) begin m_dx = 1; m_dy = -1; m_st = 1; end
    end else if (m_st == 1) begin
      ndx = m_dx; ndy = m_dy; ny = m_y;
      if (m_dx > 0) nx = (m_x + BS + SPEED >= H_RES) ? H_RES - BS : m_x + SPEED;
      else          nx = (m_x <= SPEED) ? 0 : m_x - SPEED;
      if (m_dx > 0 && m_x + BS + SPEED >= H_RES) ndx = -1;
      if (m_dx < 0 && m_x <= SPEED) ndx = 1;
      if (m_dy < 0) begin
        if (m_y <= SPEED) begin ny = 0; ndy = 1; end else ny = m_y - SPEED;
      end else if (m_y + BS <= PADDLE_Y && m_y + BS + SPEED >= PADDLE_Y &&
                   m_x + BS > padx && m_x < padx + PADDLE_W) begin
        ny = PADDLE_Y - BS; ndy = -1;
      end else if (m_y + BS + SPEED >= V_RES) begin
        ndy = 99;  // lost
      end else ny = m_y + SPEED;
      if (ndy == 99) begin
        m_miss = 1;
        m_cnt = MISS_FRAMES;
`ifdef BALL_LIVES_EN
        m_lives = m_lives - 1;
        if (m_lives == 0) begin m_st = 3; m_x = SERVE_X; m_y = SERVE_Y; end
        else m_st = 2;
`else
        m_st = 2;
`endif
      end else begin
        m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
      end
    end else if (m_st == 2) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin m_st = 0; m_x = SERVE_X; m_y = SERVE_Y; end
    end
  endtask

  // Drive one clock of stimulus and push what the outputs must be during it.
  task automatic drive_cycle(input int rst_lvl, input int pt, input int px, input int py,
                             input int padx, input int st);
    exp_t e;
    @(posedge clock);
    #1;
    reset       = rst_lvl[0];
    bus.pTick   = pt[0];
    bus.pixelX  = 10'(px);
    bus.pixelY  = 10'(py);
    bus.paddleX = 10'(padx);
    bus.start   = st[0];
    if (rst_lvl == 0) model_reset();
    e.due = cyc; e.x = m_x; e.y = m_y; e.st = m_st; e.lives = m_lives;
    e.miss = m_miss; e.sq = in_ball(px, py);
    sbq.push_back(e);
    m_miss = 0;
    if (rst_lvl != 0 && pt != 0 && px == 0 && py == V_RES) model_frame(padx, st);
  endtask

  task automatic pixel_cycle(input int padx);
    int r;
    r = $urandom % 10;
    if (r == 0)      drive_cycle(1, 0, 0, V_RES, padx, $urandom % 2);
    else if (r == 1) drive_cycle(1, 1, 1, V_RES, padx, $urandom % 2);
    else if (r == 2) drive_cycle(1, 1, 0, V_RES - 1, padx, $urandom % 2);
    else drive_cycle(1, $urandom % 2, clip(m_x - 2 + $urandom_range(0, 11), 0, H_RES - 1),
                     clip(m_y - 2 + $urandom_range(0, 11), 0, V_RES - 1), padx, $urandom % 2);
  endtask

  task automatic frame(input int padx, input int st);
    drive_cycle(1, 1, 0, V_RES, padx, st);
  endtask

  task automatic pulse_reset();
    for (int i = 0; i < 3; i++)
      drive_cycle(0, 0, SERVE_X - 1 + $urandom_range(0, 10), SERVE_Y - 1 + $urandom_range(0, 10), 0, 1);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectation for this cycle.
  always @(negedge clock) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].due < cyc) begin
      e = sbq.pop_front();
      chk("scoreboard_stale_entry", cyc, e.due);
    end
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("ballX", int'(bus.ballX), e.x);
      chk("ballY", int'(bus.ballY), e.y);
      chk("state", int'(bus.state), e.st);
      chk("lives", int'(bus.lives), e.lives);
      chk("miss", int'(bus.miss), e.miss);
      chk("squareBall", int'(bus.squareBall), e.sq);
    end
  end

  initial begin
    int track, padx, st, over_frames, mid_done;
    bus.pTick = 1'b0; bus.pixelX = '0; bus.pixelY = '0; bus.paddleX = '0; bus.start = 1'b0;
    model_reset();
    track = 1; over_frames = 0; mid_done = 0;

    pulse_reset();
    for (int f = 0; f < 3; f++) begin
      pixel_cycle(300);
      frame(300, 0);
    end
    drive_cycle(1, 0, 316, 240, 300, 0);
    drive_cycle(1, 0, 324, 240, 300, 0);
    drive_cycle(1, 0, 323, 247, 300, 0);
    drive_cycle(1, 0, 316, 248, 300, 0);
    drive_cycle(1, 0, 315, 240, 300, 0);
    frame(300, 1);
    pixel_cycle(300);
    frame(300, 0);
    pixel_cycle(300);

    for (int f = 0; f < 2500; f++) begin
      if (track != 0) padx = clip(m_x - 60 + $urandom_range(0, 66), 0, H_RES - 1);
      else if ($urandom % 10 == 0) padx = 0;
      else padx = $urandom_range(0, 1023);
      if ($urandom % 25 == 0) padx = clip(m_x + (($urandom % 2 != 0) ? BS : -PADDLE_W), 0, 1023);
      st = (m_st == 0) ? (($urandom % 3 == 0) ? 1 : 0) : $urandom % 2;
      for (int p = 0, n = $urandom_range(0, 3); p < n; p++) pixel_cycle(padx);
      frame(padx, st);
      if (m_miss != 0) track = ($urandom % 3 != 0) ? 1 : 0;
      if (mid_done == 0 && f >= 1200 && m_st == 1 && m_x != SERVE_X) begin
        pulse_reset();
        mid_done = 1;
      end
      over_frames = (m_st == 3) ? over_frames + 1 : 0;
      if (over_frames > 20) begin pulse_reset(); over_frames = 0; end
    end

    for (int i = 0; i < 3; i++) drive_cycle(1, 0, 5, 5, 0, 0);
    @(negedge clock);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ball_motion_ctrl.md
# ball_motion_ctrl

Frame-rate controller for the ball object in the breakout display pipeline. It takes the pixel scan coordinates and pixel tick from the VGA sync generator, a paddle position and a serve button. It sequences the ball through serve, move and miss phases, updating position once per frame during vertical blank, and drives `squareBall` for the colour mux. It replaces the fixed-position ball with a moving, bouncing one.

## Interface
Parameters:
- `H_RES`, 640, visible pixels per line
- `V_RES`, 480, visible lines per frame
- `BALL_SIZE`, 8, ball edge length in pixels
- `SPEED`, 2, pixels moved per axis per frame (1..BALL_SIZE)
- `SERVE_X`, 316, ball left edge in SERVE
- `SERVE_Y`, 240, ball top edge in SERVE
- `PADDLE_Y`, 460, paddle top line
- `PADDLE_W`, 64, paddle width in pixels
- `MISS_FRAMES`, 60, frames held in MISS (1..255)

Ports:
- `clock`  in  1  system clock (100 MHz)
- `reset`  in  1  asynchronous, active-low reset
- `pTick`  in  1  one-`clock` pixel enable from sync generator
- `pixelX`  in  10  current scan column
- `pixelY`  in  10  current scan line
- `paddleX`  in  10  paddle left edge
- `start`  in  1  serve request, level
- `ballX`  out  10  ball left edge
- `ballY`  out  10  ball top edge
- `squareBall`  out  1  current pixel lies inside the ball
- `miss`  out  1  one-`clock` pulse on ball loss
- `lives`  out  2  remaining lives
- `state`  out  2  SERVE=0, MOVE=1, MISS=2, OVER=3

## Operation
- `frameTick` is an internal one-`clock` strobe: `pTick && pixelX==0 && pixelY==V_RES`. All state, position and counter updates happen only on `frameTick`.
- SERVE: the ball is held at (`SERVE_X`,`SERVE_Y`). When `frameTick` occurs with `start`=1, the block sets dirX=+, dirY=- and goes to MOVE.
- MOVE, per `frameTick`, with each axis evaluated independently in the same frame:
  - X+: if `ballX+BALL_SIZE+SPEED >= H_RES`, then ballX=`H_RES-BALL_SIZE` and dirX=-; otherwise ballX+=SPEED.
  - X-: if `ballX <= SPEED`, then ballX=0 and dirX=+; otherwise ballX-=SPEED.
  - Y-: if `ballY <= SPEED`, then ballY=0 and dirY=+; otherwise ballY-=SPEED.
  - Y+, paddle hit: the ball bottom `ballY+BALL_SIZE <= PADDLE_Y` and `ballY+BALL_SIZE+SPEED >= PADDLE_Y` and `ballX+BALL_SIZE > paddleX` and `ballX < paddleX+PADDLE_W`. On a hit, ballY=`PADDLE_Y-BALL_SIZE` and dirY=-.
  - Y+, no hit: if `ballY+BALL_SIZE+SPEED >= V_RES`, then `miss` pulses, the frame counter loads `MISS_FRAMES`, and the state goes to MISS. Position freezes. Otherwise ballY+=SPEED.
  - Paddle hit has priority over bottom miss. A corner hit flips both directions in the same frame.
- MISS: the counter decrements each `frameTick`. When it reaches 0, the ball returns to the serve position and the state goes to SERVE. `start` is ignored in MISS.
- All comparisons and sums use 11-bit unsigned intermediates, so there is no wrap. `paddleX+PADDLE_W` is also 11-bit.
- `squareBall` is combinational: `pixelX>=ballX && pixelX<ballX+BALL_SIZE && pixelY>=ballY && pixelY<ballY+BALL_SIZE`.

## Timing
- Reset values: ballX=`SERVE_X`, ballY=`SERVE_Y`, dirX=+, dirY=-, state=SERVE, `miss`=0, counter=0, `lives`=3.
- Reset is asynchronous and takes effect immediately, including mid-MOVE or mid-MISS. Release is sampled on the next `clock`.
- `ballX`, `ballY`, `state` and `lives` change in the `clock` after `frameTick`, always inside vertical blank, so there is no tearing.
- `miss` is high for exactly one `clock`, in that same cycle.
- `start` asserted between ticks has no effect until the next `frameTick`. Latency from `start` to the first move is 1 frame.

## Configuration
- `BALL_LIVES_EN` defined:
  - `lives` decrements on each `miss`.
  - If a miss drops `lives` to 0, the state goes to OVER instead of MISS.
  - OVER holds the ball at the serve position and ignores `start`; only reset exits it.
- `BALL_LIVES_EN` undefined:
  - `lives` is tied to 3 and OVER is unreachable.
  - Misses always go to MISS, then SERVE.

## Test plan
- Reset, then run 3 frames with `start`=0 -> ballX=316, ballY=240, state=0, `squareBall`=1 at pixel (316,240) and 0 at (324,240).
- `start`=1 for one frame -> state=1; the next frame gives ballX=318, ballY=238.
- Preload near the top-right corner (ballX=631, ballY=1, X+/Y-) -> the next frame gives ballX=632, ballY=0, and both directions flip.
- `paddleX`=300, ball falling with ballX=310, ballY=451 -> ballY=452, dirY=-, no `miss`.
- `paddleX`=0, ball falling to the bottom -> one-`clock` `miss` pulse, state=2 for 60 frames, then state=0 at (316,240). With `BALL_LIVES_EN`, the third miss gives state=3 and `lives`=0.
- Assert reset mid-MOVE -> all outputs return to reset values asynchronously, without waiting for a `clock` edge.
